// File: rtl/hs_rx_pkg.sv
// Shared types and constants for the hs4 four-phase receive FIFO.
package hs_rx_pkg;
  typedef enum logic [1:0] {
    DRAIN    = 2'd0,
    IDLE     = 2'd1,
    WAIT_LOW = 2'd2
  } hs_rx_state_e;

  localparam int XFER_CNT_W = 16;
endpackage

// File: rtl/hs4_rx_fifo_sync_bit.sv
// Single-bit flop-chain synchronizer with a selectable reset value.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];
endmodule

// File: rtl/hs4_rx_fifo.sv
// Four-phase bundled-data receiver feeding a valid/ready FIFO (async-to-sync NoC boundary).
// Define HS_RX_STATS_EN to add the xfer_cnt write counter port.
//
// state    | meaning
// DRAIN    | after reset: wait until req has been low through the whole synchronizer
// IDLE     | ack low: capture data on req_s high when the FIFO has room
// WAIT_LOW | ack high: wait for req_s low, then drop ack
module hs4_rx_fifo
  import hs_rx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [WIDTH-1:0]      data,
  output logic                  ack,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready
`ifdef HS_RX_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  hs_rx_state_e     r_state;
  hs_rx_state_e     w_state_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             w_req_s;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  // Reset to 1 so a req still held high across reset is never seen as a new request.
  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req),
    .q     (w_req_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= DRAIN;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    case (r_state)
      DRAIN: begin
        w_ack_nxt = 1'b0;
        if (!w_req_s) w_state_nxt = IDLE;
      end
      IDLE: begin
        w_ack_nxt = 1'b0;
        // Registered count only: a same-cycle pop does not open a slot.
        if (w_req_s && (r_count < DEPTH_C)) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = DRAIN;
      end
    endcase
  end

  assign w_pop = (r_count != '0) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ack       = r_ack;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rptr];

`ifdef HS_RX_STATS_EN
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_push) begin
      r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif
endmodule

// File: doc/hs4_rx_fifo.md
# hs4_rx_fifo

Clocked receiver for the four-phase bundled-data channel produced by the asynchronous FD controller stage (`rreq`/`rack`/`rdata` side). It synchronizes the incoming request and captures the bundled data into a small FIFO. It completes the return-to-zero handshake and presents the words as a valid/ready stream to the synchronous PE/router logic downstream. It is the async-to-sync boundary of the mesh NoC.

## Interface
Parameters:
- `WIDTH`, 8, data word width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `SYNC_STAGES`, 2, flops in the request synchronizer; ≥2

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req` in 1: four-phase request from upstream (async)
- `data` in WIDTH: bundled data, stable while `req`=1
- `ack` out 1: four-phase acknowledge to upstream, registered
- `out_valid` out 1: FIFO head valid
- `out_data` out WIDTH: FIFO head word
- `out_ready` in 1: downstream accepts head when `out_valid`&&`out_ready`
- `xfer_cnt` out 16: only with `HS_RX_STATS_EN`

## Operation
- `req` passes through a `SYNC_STAGES` flop chain. The result is `req_s`. Synchronizer flops reset to 1.
- The FSM has three states:
  - DRAIN is the reset state. `ack`=0. It goes to IDLE when `req_s`=0.
  - IDLE: `ack`=0. When `req_s`=1 and count<DEPTH, it writes `data` into FIFO[wptr], sets `ack`<=1 and goes to WAIT_LOW. When the FIFO is full, it stays in IDLE and withholds `ack`.
  - WAIT_LOW: `ack`=1. When `req_s`=0, it sets `ack`<=0 and goes to IDLE.
- `data` is sampled only on the IDLE→WAIT_LOW edge. The synchronizer delay guarantees bundling margin.
- FIFO: `wptr`/`rptr` are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits wide.
  - Push and pop in the same cycle leave `count` unchanged.
  - Push eligibility uses the registered `count`. A pop in the same cycle does not enable a push into a full FIFO.
- `out_valid` = (count≠0). `out_data` = FIFO[rptr]. It holds stable while `out_valid`&&!`out_ready`.
- Exactly one FIFO write occurs per four-phase cycle. No duplicate writes and no lost words.

## Timing
- Reset values:
  - `ack`=0, `out_valid`=0, `out_data`=0
  - FIFO storage, pointers and count = 0
  - State DRAIN, `xfer_cnt`=0
- `req` rising edge to `ack` rising edge: SYNC_STAGES+1 clock edges, when the FIFO is not full.
- `req` falling edge to `ack` falling edge: SYNC_STAGES+1 clock edges.
- Write to `out_valid`: `out_valid`=1 the cycle after the write edge, when the FIFO was empty.
- Throughput: at most one word per 2·(SYNC_STAGES+1) cycles, plus upstream delays.
- Reset mid-handshake: `ack` drops to 0 and the FIFO is flushed. The FSM stays in DRAIN until `req` has been low through the whole synchronizer. A held `req` is never recaptured.
- Full FIFO with `req` high: `ack` stays 0 until a pop. Capture then occurs on the edge after `count` drops.

## Configuration
- `HS_RX_STATS_EN` defined: adds the `xfer_cnt` port. The counter increments by 1 on every FIFO write and wraps 0xFFFF→0. It clears on reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `hs_rx_pkg`: state enum `hs_rx_state_e` {DRAIN, IDLE, WAIT_LOW} and the `XFER_CNT_W`=16 constant.
- Sub-module `sync_bit #(STAGES, RST_VAL)`: a single-bit flop-chain synchronizer, instantiated once for `req`.
- The FIFO is inline. No separate module.

## Test plan
- Reset hold: `rst_n`=0 for 3 cycles with `req`=1. Required: `ack`=0, `out_valid`=0, no write. Then `req`=0 → IDLE after SYNC_STAGES+1 cycles.
- Single transfer: `data`=0xAA, `req`↑. Required: `ack`↑ 3 edges later, with `out_valid`=1 and `out_data`=0xAA. `req`↓ → `ack`↓ 3 edges later. `xfer_cnt`=1.
- Back-to-back: 0xAA then 0x55 with `out_ready`=1. Required: `out_data` gives 0xAA then 0x55, one `ack` pulse each.
- Full: `out_ready`=0 with 5 transfers 0x01..0x05. Required: the first 4 are acked. The 5th holds `ack`=0 until one pop, then captures 0x05. Output order is 0x01..0x05.
- Reset mid-handshake: reset asserted while in WAIT_LOW with `req`=1. Required: `ack`=0 and FIFO empty. After `req`↓, no spurious word.
- Pointer wrap: 10 transfers 0x10..0x19 with `out_ready`=1. Required: all 10 words in order. `xfer_cnt`=10 when stats are enabled.
